// File: rtl/tube_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : tube_scan_ctrl_pkg
// Brief  : Register map, CTRL field positions and scan FSM states shared by
//          the tube scan controller and its sub-blocks.
// Rev    : 1.0 - initial release
// ============================================================================
package tube_scan_ctrl_pkg;

  localparam logic [1:0] TUBE_ADDR_STG_LO = 2'd0;
  localparam logic [1:0] TUBE_ADDR_STG_HI = 2'd1;
  localparam logic [1:0] TUBE_ADDR_CTRL   = 2'd2;
  localparam logic [1:0] TUBE_ADDR_STATUS = 2'd3;

  localparam int CTRL_BIT_EN  = 0;
  localparam int CTRL_BIT_LZB = 1;
  localparam int CTRL_DP_LSB  = 8;

  localparam logic [7:0] TUBE_ALL_OFF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } tube_state_e;

endpackage
`default_nettype wire

// File: rtl/tube_seg_decode.sv
`default_nettype none
// ============================================================================
// Module : tube_seg_decode
// Brief  : Hex nibble to active-low seven-segment pattern, bit order g..a.
// Rev    : 1.0 - initial release
// ============================================================================
module tube_seg_decode (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    unique case (i_hex)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tube_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tube_scan_ctrl
// Brief  : 8-digit tube scanner with blank gap, staged digit registers that
//          commit at frame wrap, leading-zero blanking and dp mask.
// Rev    : 1.0 - initial release
// ============================================================================
module tube_scan_ctrl
  import tube_scan_ctrl_pkg::*;
#(
  parameter int CPU_WIDTH = 16,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [1:0]           addr,
  input  logic [CPU_WIDTH-1:0] wdata,
  output logic [CPU_WIDTH-1:0] rdata,
  output logic [7:0]           tube_en,
  output logic [7:0]           seg_led,
  output logic                 frame_pulse
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] C_SHOW_LAST  = CNT_W'(SCAN_DIV - BLANK_CYC - 1);

  tube_state_e            r_state, w_state_nxt;
  logic [2:0]             r_idx, w_idx_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [CPU_WIDTH-1:0]   r_stg_lo, r_stg_hi, r_ctrl;
  logic [CPU_WIDTH-1:0]   w_stg_lo_nxt, w_stg_hi_nxt;
  logic [2*CPU_WIDTH-1:0] r_live;
  logic [7:0]             r_frame_cnt;
  logic                   w_en, w_wrap, w_blank_digit;
  logic [7:0]             w_lz, w_dp_mask;
  logic [3:0]             w_nib;
  logic [6:0]             w_seg;

  assign w_en      = r_ctrl[CTRL_BIT_EN];
  assign w_dp_mask = r_ctrl[CTRL_DP_LSB +: 8];

  // Same-cycle staging writes are folded in so a write on the commit cycle lands in LIVE.
  assign w_stg_lo_nxt = (wr_en && addr == TUBE_ADDR_STG_LO) ? wdata : r_stg_lo;
  assign w_stg_hi_nxt = (wr_en && addr == TUBE_ADDR_STG_HI) ? wdata : r_stg_hi;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_wrap      = 1'b0;
    if (!w_en) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = 3'd0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
        end
        ST_BLANK: begin
          if (r_cnt == C_BLANK_LAST) begin
            w_state_nxt = ST_SHOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (r_cnt == C_SHOW_LAST) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 3'd1;
            w_wrap      = (r_idx == 3'd7);
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_lo    <= '0;
      r_stg_hi    <= '0;
      r_ctrl      <= '0;
      r_live      <= '0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_stg_lo <= w_stg_lo_nxt;
      r_stg_hi <= w_stg_hi_nxt;
      if (wr_en && addr == TUBE_ADDR_CTRL) r_ctrl <= wdata;
      if (w_wrap) begin
        r_live      <= {w_stg_hi_nxt, w_stg_lo_nxt};
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  // w_lz[k] is set when LIVE digits 7..k are all zero.
  always_comb begin
    w_lz    = 8'h00;
    w_lz[7] = (r_live[31:28] == 4'd0);
    for (int k = 6; k >= 0; k--) begin
      w_lz[k] = w_lz[k+1] && (r_live[k*4 +: 4] == 4'd0);
    end
  end

  assign w_nib         = r_live[{r_idx, 2'b00} +: 4];
  assign w_blank_digit = r_ctrl[CTRL_BIT_LZB] && (r_idx != 3'd0) && w_lz[r_idx];

  tube_seg_decode u_seg_decode (
    .i_hex (w_nib),
    .o_seg (w_seg)
  );

  always_comb begin
    tube_en = TUBE_ALL_OFF;
    seg_led = TUBE_ALL_OFF;
    if (r_state == ST_SHOW) begin
      tube_en = ~(8'd1 << r_idx);
      seg_led = {~w_dp_mask[r_idx], (w_blank_digit ? 7'h7F : w_seg)};
    end
  end

  assign frame_pulse = w_wrap;

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      unique case (addr)
        TUBE_ADDR_STG_LO: rdata = r_stg_lo;
        TUBE_ADDR_STG_HI: rdata = r_stg_hi;
        TUBE_ADDR_CTRL:   rdata = r_ctrl;
        TUBE_ADDR_STATUS: rdata = {r_frame_cnt, 4'd0, (r_state == ST_SHOW), r_idx};
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tube_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_tube_scan_ctrl
// Brief  : Scoreboard bench for tube_scan_ctrl with SCAN_DIV=10, BLANK_CYC=2.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_tube_scan_ctrl;

  localparam int SCAN_DIV  = 10;
  localparam int BLANK_CYC = 2;
  localparam int SHOW_LEN  = SCAN_DIV - BLANK_CYC;
  localparam int FRAME_LEN = 8 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [15:0] wdata = 16'd0;
  logic [15:0] rdata;
  logic [7:0]  tube_en, seg_led;
  logic        frame_pulse;

  typedef struct packed {
    logic [7:0] tube;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   fp_check = 1'b0;

  tube_scan_ctrl #(
    .CPU_WIDTH (16),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .tube_en     (tube_en),
    .seg_led     (seg_led),
    .frame_pulse (frame_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  task automatic push_digit(input int k, input logic [7:0] seg);
    exp_t e;
    e.tube = ~(8'd1 << k);
    e.seg  = seg;
    exp_q.push_back(e);
  endtask

  task automatic push_hex_frame(input logic [31:0] live, input int n);
    for (int k = 0; k < n; k++) push_digit(k, seg_of(live[k*4 +: 4]));
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic bus_read_chk(input string nm, input logic [1:0] a, input logic [15:0] exp);
    @(posedge clk); #1;
    rd_en = 1'b1; addr = a;
    @(negedge clk);
    chk(nm, 32'(rdata), 32'(exp));
    rd_en = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int b = 0;
    while (exp_q.size() > n && b < 400) begin
      @(negedge clk);
      b++;
    end
    chk("queue_drain_timeout", 32'(exp_q.size() > n), 32'd0);
  endtask

  task automatic wait_slot(input logic [7:0] tube);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (tube_en === tube) seen = 1'b1;
    end
    chk("slot_wait_timeout", 32'(seen), 32'd1);
  endtask

  task automatic check_start_latency(input string nm);
    int  t0;
    bit  seen;
    t0   = cyc;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tube_en !== 8'hFF) seen = 1'b1;
    end
    chk(nm, 32'(cyc - t0), 32'd3);
  endtask

  // Lands the write on the last SHOW cycle of digit 7, i.e. the frame_pulse cycle.
  task automatic write_at_pulse(input logic [1:0] a, input logic [15:0] d);
    wait_slot(8'h7F);
    repeat (SHOW_LEN - 2) @(posedge clk);
    @(posedge clk); #1;
    wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    chk("fp_coincide", 32'(frame_pulse), 32'd1);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Monitor: pops one expectation per digit slot, checks slot length and frame period.
  bit         in_slot = 1'b0;
  int         slot_len = 0;
  bit         fp_seen = 1'b0;
  int         fp_last = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_slot = 1'b0;
      slot_len = 0;
      fp_seen = 1'b0;
    end else begin
      if (!fp_check) fp_seen = 1'b0;
      else if (frame_pulse) begin
        if (fp_seen) chk("frame_period", 32'(cyc - fp_last), 32'(FRAME_LEN));
        fp_seen = 1'b1;
        fp_last = cyc;
      end
      if (tube_en !== 8'hFF) begin
        if (!in_slot) begin
          in_slot  = 1'b1;
          slot_len = 1;
          if (exp_q.size() == 0) begin
            chk("unexpected_slot", {24'd0, tube_en}, 32'hFF);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("slot_tube", 32'(tube_en), 32'(e.tube));
            chk("slot_seg", 32'(seg_led), 32'(e.seg));
          end
        end else begin
          slot_len++;
        end
      end else if (in_slot) begin
        in_slot = 1'b0;
        chk("slot_len", 32'(slot_len), 32'(SHOW_LEN));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tube", 32'(tube_en), 32'hFF);
    chk("rst_seg", 32'(seg_led), 32'hFF);
    chk("rst_fp", 32'(frame_pulse), 32'd0);
    rd_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1 chk("rst_rdata", 32'(rdata), 32'd0);
    end
    rd_en = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Register access and the read-only STATUS
    bus_write(2'd0, 16'h3210);
    bus_write(2'd1, 16'h7654);
    bus_write(2'd3, 16'hFFFF);
    bus_read_chk("rd_stg_lo", 2'd0, 16'h3210);
    bus_read_chk("rd_stg_hi", 2'd1, 16'h7654);
    bus_read_chk("rd_status_ro", 2'd3, 16'h0000);
    @(negedge clk);
    chk("rd_en_low_zero", 32'(rdata), 32'd0);

    // Frame A shows the still-zero LIVE; B onwards shows the committed staging.
    push_hex_frame(32'h0000_0000, 8);
    push_hex_frame(32'h7654_3210, 8);
    push_hex_frame(32'h7654_3210, 8);
    bus_write(2'd2, 16'h0001);
    check_start_latency("start_latency");
    fp_check = 1'b1;

    // Mid-frame write in C: digits 2,3 of C keep old values, D shows 8s.
    wait_q(6);
    bus_write(2'd0, 16'h8888);
    push_hex_frame(32'h7654_8888, 8);
    wait_q(1);
    write_at_pulse(2'd0, 16'h1111);
    push_hex_frame(32'h7654_1111, 8);

    // Leading-zero blank with LIVE=0x00000050, then LIVE=0.
    wait_q(7);
    bus_write(2'd0, 16'h0050);
    bus_write(2'd1, 16'h0000);
    bus_write(2'd2, 16'h0003);
    push_digit(0, 8'hC0);
    push_digit(1, 8'h92);
    for (int k = 2; k < 8; k++) push_digit(k, 8'hFF);
    wait_q(7);
    bus_write(2'd0, 16'h0000);
    push_digit(0, 8'hC0);
    for (int k = 1; k < 8; k++) push_digit(k, 8'hFF);

    // dp mask on digit 7 only, applied from the first cycle of frame H.
    wait_q(1);
    write_at_pulse(2'd2, 16'h8001);
    for (int k = 0; k < 7; k++) push_digit(k, 8'hC0);
    push_digit(7, 8'h40);
    push_hex_frame(32'h0000_0000, 5);

    // Disable during the BLANK gap ahead of digit 5 of frame I.
    wait_q(1);
    fp_check = 1'b0;
    wait_slot(8'hEF);
    repeat (SHOW_LEN - 1) @(posedge clk);
    @(posedge clk); #1;
    wr_en = 1'b1; addr = 2'd2; wdata = 16'h0000;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b1; addr = 2'd3;
    @(negedge clk);
    chk("status_idx5", 32'(rdata), 32'h0805);
    @(negedge clk);
    chk("status_idle", 32'(rdata), 32'h0800);
    chk("idle_tube", 32'(tube_en), 32'hFF);
    chk("idle_seg", 32'(seg_led), 32'hFF);
    rd_en = 1'b0;
    repeat (15) @(negedge clk);
    chk("idle_stays_off", 32'(tube_en), 32'hFF);

    // Re-enable restarts at digit 0 after the blank gap.
    push_hex_frame(32'h0000_0000, 8);
    bus_write(2'd2, 16'h0001);
    check_start_latency("restart_latency");

    // Asynchronous reset in the middle of digit 7's SHOW slot.
    wait_q(0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_tube", 32'(tube_en), 32'hFF);
    chk("midrst_seg", 32'(seg_led), 32'hFF);
    chk("midrst_fp", 32'(frame_pulse), 32'd0);
    rd_en = 1'b1; addr = 2'd3;
    #1 chk("midrst_status", 32'(rdata), 32'd0);
    addr = 2'd0;
    #1 chk("midrst_stg_lo", 32'(rdata), 32'd0);
    addr = 2'd2;
    #1 chk("midrst_ctrl", 32'(rdata), 32'd0);
    rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_off", 32'(tube_en), 32'hFF);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
